fm0_miller_encoder: RTL and testbench

- Parametrised successor to the FM0-only tag-side encoder: line-codes a bit stream as FM0 or Miller M=2/4/8 with a square-wave subcarrier.
- Optionally prepends the Gen2 pilot tone and preamble, and appends the dummy-1 terminator.
- Used as backscatter stimulus for bits_detector benches and as the reference encoder for multi-mode detector work.
- Paced by an external sample strobe from strb_gen.

---
 rtl/fm0_miller_encoder_if.sv | 31 +++
 rtl/fm0_miller_encoder.sv | 193 +++++++++++++++++++
 tb/tb_fm0_miller_encoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fm0_miller_encoder_if.sv
// Data, control and line-side signals of the FM0/Miller backscatter encoder.
// The master (stimulus) side drives frame control, data and sample strobe.
interface fm0_miller_encoder_if #(
  parameter int HALF_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [HALF_W-1:0] half_len;
  logic              pre_en;
  logic              trext;
  logic              in_bit;
  logic              in_vld;
  logic              in_last;
  logic              in_rdy;
  logic              out_stb;
  logic              out_dat;
  logic              busy;
  logic              underrun;

  modport master (
    output start, mode, half_len, pre_en, trext,
    output in_bit, in_vld, in_last, out_stb,
    input  in_rdy, out_dat, busy, underrun
  );

  modport slave (
    input  start, mode, half_len, pre_en, trext,
    input  in_bit, in_vld, in_last, out_stb,
    output in_rdy, out_dat, busy, underrun
  );
endinterface

// File: rtl/fm0_miller_encoder.sv
// Tag-side line encoder: FM0 or Miller M=2/4/8 with optional Gen2 pilot and
// preamble, trailing dummy-1 symbol, paced by an external sample strobe.
module fm0_miller_encoder #(
  parameter int               HALF_W       = 8,
  parameter int               PRE_LEN      = 6,
  parameter logic [PRE_LEN-1:0] PRE_FM0    = 6'b101001,
  parameter logic [PRE_LEN-1:0] PRE_MIL    = 6'b010111,
  parameter int               FM0_VIOL_IDX = 4
) (
  input logic               clk,
  input logic               rst,
  fm0_miller_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PILOT, PRE, DATA, DUMMY} state_t;

  state_t            state_reg;
  logic [1:0]        mode_reg;
  logic [HALF_W-1:0] hl_reg;
  logic [HALF_W-1:0] tick_reg;
  logic [3:0]        h_reg;
  logic [4:0]        sym_reg;
  logic [4:0]        pilot_last_reg;
  logic              bit_reg;
  logic              prev_reg;
  logic              lvl_reg;
  logic              entry_reg;
  logic              last_reg;
  logic              out_dat_reg;
  logic              busy_reg;
  logic              underrun_reg;

  logic               is_fm0;
  logic [3:0]         h_last;
  logic [3:0]         h_mid;
  logic               first_tick;
  logic               tick_last;
  logic               sym_end;
  logic [PRE_LEN-1:0] pre_shift;
  logic               pre_bit;
  logic               viol;
  logic               cur_bit;
  logic               toggle;
  logic               lvl_next;
  logic               out_next;
  logic               rdy;
  logic               take;
  logic               starve;
  logic [4:0]         pilot_n;

  always_comb begin
    is_fm0     = (mode_reg == 2'd0);
    h_last     = {mode_reg == 2'd3, mode_reg >= 2'd2, mode_reg >= 2'd1, 1'b1};
    h_mid      = 4'b0001 << mode_reg;
    first_tick = (tick_reg == '0);
    tick_last  = (tick_reg == hl_reg - HALF_W'(1));
    sym_end    = tick_last && (h_reg == h_last);
    pre_shift  = (is_fm0 ? PRE_FM0 : PRE_MIL) << sym_reg;
    pre_bit    = pre_shift[PRE_LEN-1];
    viol       = is_fm0 && (state_reg == PRE) && (sym_reg == 5'(FM0_VIOL_IDX));

    // A data symbol starts either on the first strobe in DATA or right after the previous one ends.
    rdy    = bus.out_stb && (state_reg == DATA) && (entry_reg || (sym_end && !last_reg));
    take   = rdy && bus.in_vld;
    starve = rdy && !bus.in_vld;

    cur_bit = 1'b0;
    case (state_reg)
      PRE:     cur_bit = pre_bit;
      DATA:    cur_bit = entry_reg ? (bus.in_vld ? bus.in_bit : 1'b1) : bit_reg;
      DUMMY:   cur_bit = 1'b1;
      default: cur_bit = 1'b0;
    endcase

    if (is_fm0) begin
      toggle = first_tick && (((h_reg == 4'd0) && !viol) || ((h_reg == 4'd1) && !cur_bit));
    end else begin
      toggle = first_tick && (((h_reg == 4'd0) && !cur_bit && !prev_reg) ||
                              ((h_reg == h_mid) && cur_bit));
    end
    lvl_next = lvl_reg ^ toggle;
    out_next = is_fm0 ? lvl_next : (lvl_next ^ h_reg[0]);

    if (bus.mode == 2'd0) begin
      pilot_n = bus.trext ? 5'd12 : 5'd0;
    end else begin
      pilot_n = bus.trext ? 5'd16 : 5'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mode_reg       <= '0;
      hl_reg         <= '0;
      tick_reg       <= '0;
      h_reg          <= '0;
      sym_reg        <= '0;
      pilot_last_reg <= '0;
      bit_reg        <= 1'b0;
      prev_reg       <= 1'b0;
      lvl_reg        <= 1'b0;
      entry_reg      <= 1'b0;
      last_reg       <= 1'b0;
      out_dat_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      underrun_reg <= starve;
      if (state_reg == IDLE) begin
        if (bus.start) begin
          mode_reg       <= bus.mode;
          hl_reg         <= (bus.half_len == '0) ? HALF_W'(1) : bus.half_len;
          pilot_last_reg <= pilot_n - 5'd1;
          busy_reg       <= 1'b1;
          lvl_reg        <= 1'b0;
          prev_reg       <= 1'b1;
          tick_reg       <= '0;
          h_reg          <= '0;
          sym_reg        <= '0;
          last_reg       <= 1'b0;
          entry_reg      <= !bus.pre_en;
          if (!bus.pre_en) begin
            state_reg <= DATA;
          end else if (pilot_n != 5'd0) begin
            state_reg <= PILOT;
          end else begin
            state_reg <= PRE;
          end
        end else if (bus.out_stb) begin
          // The last dummy sample stays on the line until the following strobe.
          out_dat_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      end else if (bus.out_stb) begin
        lvl_reg     <= lvl_next;
        out_dat_reg <= out_next;

        if (tick_last) begin
          tick_reg <= '0;
          h_reg    <= (h_reg == h_last) ? 4'd0 : h_reg + 4'd1;
        end else begin
          tick_reg <= tick_reg + HALF_W'(1);
        end

        if (entry_reg) begin
          entry_reg <= 1'b0;
          bit_reg   <= bus.in_bit;
          last_reg  <= bus.in_last;
          if (!bus.in_vld) begin
            state_reg <= DUMMY;
          end
        end

        if (sym_end) begin
          prev_reg <= cur_bit;
          case (state_reg)
            PILOT: begin
              if (sym_reg == pilot_last_reg) begin
                state_reg <= PRE;
                sym_reg   <= '0;
              end else begin
                sym_reg <= sym_reg + 5'd1;
              end
            end
            PRE: begin
              if (sym_reg == 5'(PRE_LEN - 1)) begin
                state_reg <= DATA;
                entry_reg <= 1'b1;
                sym_reg   <= '0;
              end else begin
                sym_reg <= sym_reg + 5'd1;
              end
            end
            DATA: begin
              if (take) begin
                bit_reg  <= bus.in_bit;
                last_reg <= bus.in_last;
              end else begin
                state_reg <= DUMMY;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.in_rdy   = rdy;
  assign bus.out_dat  = out_dat_reg;
  assign bus.busy     = busy_reg;
  assign bus.underrun = underrun_reg;
endmodule

// File: tb/tb_fm0_miller_encoder.sv
// Directed bench for fm0_miller_encoder: hand-derived per-symbol half patterns
// checked sample by sample, plus handshake, underrun, gating and reset checks.
module tb_fm0_miller_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fm0_miller_encoder_if #(.HALF_W(8)) bus();
  fm0_miller_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_cnt, under_cnt, feed_idx, feed_n, stall_rdy;
  logic [7:0] feed;
  logic rdy_v;
  logic gap_en;
  logic last_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic stb);
    @(negedge clk);
    bus.out_stb = stb;
    if (feed_idx < feed_n) begin
      bus.in_vld  = (rdy_cnt != stall_rdy);
      bus.in_bit  = feed[feed_idx];
      bus.in_last = (feed_idx == feed_n - 1);
    end else begin
      bus.in_vld  = 1'b0;
      bus.in_bit  = 1'b0;
      bus.in_last = 1'b0;
    end
    #1;
    rdy_v = bus.in_rdy;
    if (rdy_v) begin
      rdy_cnt++;
      if (bus.in_vld) feed_idx++;
    end
    @(posedge clk);
    #1;
    if (bus.underrun) under_cnt++;
  endtask

  task automatic set_feed(input logic [7:0] bits, input int n, input int stall);
    feed      = bits;
    feed_n    = n;
    feed_idx  = 0;
    stall_rdy = stall;
    rdy_cnt   = 0;
    under_cnt = 0;
  endtask

  task automatic start_frame(input string tag, input logic [1:0] m, input logic [7:0] hl,
                             input logic pe, input logic tx);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.half_len = hl;
    bus.pre_en   = pe;
    bus.trext    = tx;
    bus.out_stb  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, " start busy"}, bus.busy, 1);
    chk({tag, " start out"}, bus.out_dat, 0);
    last_exp = 1'b0;
  endtask

  // halves: expected level per half-period, first half in the MSB of the nh used bits
  task automatic run_sym(input string tag, input logic [15:0] halves, input int nh, input int hl);
    for (int h = 0; h < nh; h++) begin
      for (int t = 0; t < hl; t++) begin
        if (gap_en) begin
          cyc(1'b0);
          chk({tag, " gap hold"}, bus.out_dat, last_exp);
          chk({tag, " gap rdy"}, rdy_v, 0);
        end
        cyc(1'b1);
        last_exp = halves[nh-1-h];
        chk(tag, bus.out_dat, last_exp);
        chk({tag, " busy"}, bus.busy, 1);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    cyc(1'b1);
    chk({tag, " idle out"}, bus.out_dat, 0);
    chk({tag, " idle busy"}, bus.busy, 0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 2'd0;
    bus.half_len = 8'd1;
    bus.pre_en   = 1'b0;
    bus.trext    = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_vld   = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_stb  = 1'b1;
    gap_en       = 1'b0;
    set_feed(8'h00, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", bus.out_dat, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset underrun", bus.underrun, 0);
    chk("reset rdy", bus.in_rdy, 0);
    rst = 1'b0;

    // FM0, half_len=2, bits 1,0,1
    set_feed(8'b0000_0101, 3, -1);
    start_frame("t1", 2'd0, 8'd2, 1'b0, 1'b0);
    run_sym("t1 d1", 16'b11, 2, 2);
    run_sym("t1 d0", 16'b01, 2, 2);
    run_sym("t1 d1b", 16'b00, 2, 2);
    run_sym("t1 dummy", 16'b11, 2, 2);
    idle_check("t1");
    chk("t1 rdy pulses", rdy_cnt, 3);
    chk("t1 underruns", under_cnt, 0);

    // Miller2, half_len=1, bits 1,0,0 with strobe gaps
    set_feed(8'b0000_0001, 3, -1);
    gap_en = 1'b1;
    start_frame("t2", 2'd1, 8'd1, 1'b0, 1'b0);
    run_sym("t2 d1", 16'b0110, 4, 1);
    run_sym("t2 d0", 16'b1010, 4, 1);
    run_sym("t2 d0b", 16'b0101, 4, 1);
    run_sym("t2 dummy", 16'b0110, 4, 1);
    gap_en = 1'b0;
    idle_check("t2");
    chk("t2 rdy pulses", rdy_cnt, 3);

    // FM0, pilot extended, preamble with violation, half_len=0 acting as 1
    set_feed(8'b0000_0001, 1, -1);
    start_frame("t3", 2'd0, 8'd0, 1'b1, 1'b1);
    for (int s = 0; s < 12; s++) run_sym("t3 pilot", 16'b10, 2, 1);
    run_sym("t3 pre0", 16'b11, 2, 1);
    run_sym("t3 pre1", 16'b01, 2, 1);
    run_sym("t3 pre2", 16'b00, 2, 1);
    run_sym("t3 pre3", 16'b10, 2, 1);
    run_sym("t3 pre4 viol", 16'b01, 2, 1);
    run_sym("t3 pre5", 16'b00, 2, 1);
    chk("t3 no rdy before data", rdy_cnt, 0);
    run_sym("t3 d1", 16'b11, 2, 1);
    run_sym("t3 dummy", 16'b00, 2, 1);
    idle_check("t3");
    chk("t3 rdy pulses", rdy_cnt, 1);

    // Miller4, pilot of 4, preamble 010111, half_len=2
    set_feed(8'b0000_0000, 1, -1);
    start_frame("t4", 2'd2, 8'd2, 1'b1, 1'b0);
    run_sym("t4 pilot0", 16'b01010101, 8, 2);
    run_sym("t4 pilot1", 16'b10101010, 8, 2);
    run_sym("t4 pilot2", 16'b01010101, 8, 2);
    run_sym("t4 pilot3", 16'b10101010, 8, 2);
    run_sym("t4 pre0", 16'b01010101, 8, 2);
    run_sym("t4 pre1", 16'b01011010, 8, 2);
    run_sym("t4 pre2", 16'b10101010, 8, 2);
    run_sym("t4 pre3", 16'b10100101, 8, 2);
    run_sym("t4 pre4", 16'b01011010, 8, 2);
    run_sym("t4 pre5", 16'b10100101, 8, 2);
    chk("t4 no rdy in 10 symbols", rdy_cnt, 0);
    run_sym("t4 d0", 16'b01010101, 8, 2);
    chk("t4 rdy after 10 symbols", rdy_cnt, 1);
    run_sym("t4 dummy", 16'b01011010, 8, 2);
    idle_check("t4");

    // Underrun at the second in_rdy; start while busy is ignored
    set_feed(8'b0000_0010, 2, 1);
    start_frame("t5", 2'd0, 8'd1, 1'b0, 1'b0);
    run_sym("t5 d0", 16'b10, 2, 1);
    chk("t5 underrun pulse", under_cnt, 1);
    bus.start = 1'b1;
    bus.mode  = 2'd3;
    run_sym("t5 dummy", 16'b11, 2, 1);
    bus.start = 1'b0;
    idle_check("t5");
    idle_check("t5 stays");
    chk("t5 underrun once", under_cnt, 1);
    chk("t5 rdy pulses", rdy_cnt, 2);

    // Reset mid-DATA, then a clean frame
    set_feed(8'b0000_0010, 4, -1);
    start_frame("t6", 2'd0, 8'd1, 1'b0, 1'b0);
    run_sym("t6 d0", 16'b10, 2, 1);
    cyc(1'b1);
    chk("t6 d1 half0", bus.out_dat, 1);
    @(negedge clk);
    rst = 1'b1;
    bus.out_stb = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6 rst out", bus.out_dat, 0);
    chk("t6 rst busy", bus.busy, 0);
    chk("t6 rst rdy", bus.in_rdy, 0);
    set_feed(8'b0000_0000, 1, -1);
    start_frame("t6b", 2'd0, 8'd1, 1'b0, 1'b0);
    run_sym("t6b d0", 16'b10, 2, 1);
    run_sym("t6b dummy", 16'b11, 2, 1);
    idle_check("t6b");
    chk("t6b rdy pulses", rdy_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
